// File: rtl/test_cfg_spi_resp.sv
// SPI mode-0 slave exposing eight 8-bit configuration registers.
// Frame: bit15 RW (1 = write), bits14:11 ignored, bits10:8 address, bits7:0 data.
// Optional readback of registers over miso is enabled with `define SPI_READBACK_EN.
module test_cfg_spi_resp #(
  parameter logic [7:0]  RESET_VAL   = 8'h00,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe,
  output logic [63:0] cfg,
  output logic        frame_done,
  output logic [7:0]  frame_cnt
);

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic [SYNC_STAGES-1:0] vld_q;
  logic                   sclk_prev_q;
  logic                   cs_prev_q;
  logic                   armed_q;
  logic [7:0]             shift_q;
  logic [3:0]             bit_cnt_q;
  logic                   rw_q;
  logic [2:0]             addr_q;
  logic [7:0]             regs_q [8];
  logic                   frame_done_q;
  logic [7:0]             frame_cnt_q;

  logic sclk_s, cs_s, mosi_s, sync_vld;
  logic sclk_rise, cs_rise, cs_fall;
  logic [7:0] shift_nxt;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  // Edges are only trusted once the synchroniser has been refilled with real
  // samples after reset; the reset fill values would otherwise fake edges.
  assign sync_vld  = vld_q[SYNC_STAGES-1];
  assign sclk_rise = sync_vld & sclk_s & ~sclk_prev_q;
  assign cs_rise   = sync_vld & cs_s & ~cs_prev_q;
  assign cs_fall   = sync_vld & ~cs_s & cs_prev_q;
  assign shift_nxt = {shift_q[6:0], mosi_s};

`ifdef SPI_READBACK_EN
  logic       sclk_fall;
  logic [7:0] shadow_q;
  logic       miso_q;
  logic       miso_oe_q;
  assign sclk_fall = sync_vld & ~sclk_s & sclk_prev_q;
  assign miso      = miso_q;
  assign miso_oe   = miso_oe_q;
`else
  assign miso      = 1'b0;
  assign miso_oe   = 1'b0;
`endif

  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;

  // Flatten the register file onto the cfg bus, reg[n] at cfg[8n+7:8n].
  always_comb begin
    cfg = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      cfg[8*i +: 8] = regs_q[i];
    end
  end

  // Synchronisers, edge history, frame FSM, register file and outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q  <= '0;
      cs_sync_q    <= '1;
      mosi_sync_q  <= '0;
      vld_q        <= '0;
      sclk_prev_q  <= 1'b0;
      cs_prev_q    <= 1'b1;
      armed_q      <= 1'b0;
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      rw_q         <= 1'b0;
      addr_q       <= '0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
      for (int unsigned i = 0; i < 8; i++) begin
        regs_q[i] <= RESET_VAL;
      end
`ifdef SPI_READBACK_EN
      shadow_q     <= '0;
      miso_q       <= 1'b0;
      miso_oe_q    <= 1'b0;
`endif
    end else begin
      sclk_sync_q  <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      cs_sync_q    <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
      mosi_sync_q  <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      vld_q        <= {vld_q[SYNC_STAGES-2:0], 1'b1};
      sclk_prev_q  <= sclk_s;
      cs_prev_q    <= cs_s;
      // A frame may only start after cs_n has genuinely been seen high.
      armed_q      <= armed_q | (sync_vld & cs_s);
      frame_done_q <= 1'b0;
`ifdef SPI_READBACK_EN
      miso_oe_q    <= ~cs_s;
`endif
      case (state_q)
        IDLE: begin
          if (armed_q && cs_fall) begin
            state_q   <= CMD;
            bit_cnt_q <= '0;
            shift_q   <= '0;
          end
        end
        CMD: begin
          if (cs_rise) begin
            state_q <= IDLE;
          end else if (sclk_rise) begin
            shift_q   <= shift_nxt;
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              state_q <= DATA;
              rw_q    <= shift_nxt[7];
              addr_q  <= shift_nxt[2:0];
`ifdef SPI_READBACK_EN
              if (!shift_nxt[7]) begin
                shadow_q <= regs_q[shift_nxt[2:0]];
              end
`endif
            end
          end
        end
        DATA: begin
          // The 16th rise wins over a simultaneous cs_n rise.
          if (sclk_rise && bit_cnt_q == 4'd15) begin
            bit_cnt_q    <= bit_cnt_q + 4'd1;
            shift_q      <= shift_nxt;
            frame_done_q <= 1'b1;
            frame_cnt_q  <= frame_cnt_q + 8'd1;
            if (rw_q) begin
              regs_q[addr_q] <= shift_nxt;
            end
            state_q <= cs_rise ? IDLE : DONE;
`ifdef SPI_READBACK_EN
            miso_q  <= 1'b0;
`endif
          end else if (cs_rise) begin
            state_q <= IDLE;
`ifdef SPI_READBACK_EN
            miso_q  <= 1'b0;
`endif
          end else begin
            if (sclk_rise) begin
              shift_q   <= shift_nxt;
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
`ifdef SPI_READBACK_EN
            if (sclk_fall && !rw_q) begin
              miso_q   <= shadow_q[7];
              shadow_q <= {shadow_q[6:0], 1'b0};
            end
`endif
          end
        end
        DONE: begin
          if (cs_rise) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_test_cfg_spi_resp.sv
// Self-checking bench for test_cfg_spi_resp with a frame_done scoreboard.
module tb_test_cfg_spi_resp;

  localparam logic [7:0]  RV   = 8'h00;
  localparam int unsigned HALF = 5;
`ifdef SPI_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sclk = 1'b0;
  logic        cs_n = 1'b1;
  logic        mosi = 1'b0;
  logic        miso;
  logic        miso_oe;
  logic [63:0] cfg;
  logic        frame_done;
  logic [7:0]  frame_cnt;

  test_cfg_spi_resp #(.RESET_VAL(RV), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .cfg(cfg),
    .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int unsigned vec_cnt = 0;
  int unsigned err_cnt = 0;
  int unsigned done_pulses = 0;
  logic [7:0]  exp_q [$];
  logic [7:0]  cnt_mdl = 8'd0;
  logic [7:0]  mdl [8];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mdl_cfg();
    logic [63:0] v;
    for (int unsigned i = 0; i < 8; i++) v[8*i +: 8] = mdl[i];
    return v;
  endfunction

  function automatic void push_frame();
    cnt_mdl = cnt_mdl + 8'd1;
    exp_q.push_back(cnt_mdl);
  endfunction

  function automatic void mdl_reset();
    for (int unsigned i = 0; i < 8; i++) mdl[i] = RV;
    cnt_mdl = 8'd0;
    exp_q.delete();
  endfunction

  // Scoreboard: each frame_done pulse pops the expected frame count.
  always @(negedge clk) begin
    if (frame_done === 1'b1) begin
      done_pulses++;
      if (exp_q.size() == 0) check("unexpected_done", 64'd1, 64'd0);
      else check("frame_cnt_at_done", {56'd0, frame_cnt}, {56'd0, exp_q.pop_front()});
    end
  end

  task automatic wait_clk(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clk_bits(input logic [31:0] data, input int unsigned nbits, output logic [31:0] rx);
    rx = '0;
    for (int unsigned i = 0; i < nbits; i++) begin
      mosi = data[nbits-1-i];
      wait_clk(HALF);
      rx[nbits-1-i] = miso;
      sclk = 1'b1;
      wait_clk(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic spi_xfer(input logic [31:0] data, input int unsigned nbits, output logic [31:0] rx);
    cs_n = 1'b0;
    wait_clk(HALF);
    check("miso_oe_active", {63'd0, miso_oe}, {63'd0, RB});
    clk_bits(data, nbits, rx);
    wait_clk(HALF);
    cs_n = 1'b1;
    wait_clk(2*HALF);
    check("miso_oe_idle", {63'd0, miso_oe}, 64'd0);
  endtask

  initial begin
    logic [31:0] rx;
    int unsigned pulses0;
    logic [7:0]  cnt0;

    mdl_reset();
    wait_clk(5);
    // Outputs while reset is asserted.
    check("rst_cfg", cfg, mdl_cfg());
    check("rst_frame_cnt", {56'd0, frame_cnt}, 64'd0);
    check("rst_frame_done", {63'd0, frame_done}, 64'd0);
    check("rst_miso", {63'd0, miso}, 64'd0);
    check("rst_miso_oe", {63'd0, miso_oe}, 64'd0);
    rst = 1'b0;
    wait_clk(10);

    // Write 0x83A5.
    pulses0 = done_pulses;
    push_frame(); mdl[3] = 8'hA5;
    spi_xfer(32'h83A5, 16, rx);
    check("wr_cfg", cfg, mdl_cfg());
    check("wr_frame_cnt", {56'd0, frame_cnt}, 64'd1);
    check("wr_pulses", 64'(done_pulses - pulses0), 64'd1);
    check("wr_miso_zero", {48'd0, rx[15:0]}, 64'd0);

    // Read back reg3.
    push_frame();
    spi_xfer(32'h0300, 16, rx);
    check("rd_miso", {48'd0, rx[15:0]}, RB ? 64'h00A5 : 64'd0);
    check("rd_cfg", cfg, mdl_cfg());
    check("rd_frame_cnt", {56'd0, frame_cnt}, 64'd2);

    // Abort after 12 bits of write 0x8277.
    pulses0 = done_pulses;
    spi_xfer(32'h827, 12, rx);
    check("abort_cfg", cfg, mdl_cfg());
    check("abort_frame_cnt", {56'd0, frame_cnt}, 64'd2);
    check("abort_pulses", 64'(done_pulses - pulses0), 64'd0);

    // 20 bits, first 16 = 0x8711, trailing bits 0xF ignored.
    pulses0 = done_pulses;
    push_frame(); mdl[7] = 8'h11;
    spi_xfer(32'h8711F, 20, rx);
    check("long_cfg", cfg, mdl_cfg());
    check("long_pulses", 64'(done_pulses - pulses0), 64'd1);
    check("long_frame_cnt", {56'd0, frame_cnt}, 64'd3);

    // Give reg1 a non-reset value, then reset in the middle of a write.
    push_frame(); mdl[1] = 8'h3C;
    spi_xfer(32'h813C, 16, rx);
    check("pre_rst_cfg", cfg, mdl_cfg());
    cs_n = 1'b0;
    wait_clk(HALF);
    clk_bits(32'h8155 >> 6, 10, rx);
    rst = 1'b1;
    mdl_reset();
    wait_clk(3);
    rst = 1'b0;
    wait_clk(10);
    check("midrst_cfg", cfg, mdl_cfg());
    check("midrst_frame_cnt", {56'd0, frame_cnt}, 64'd0);
    pulses0 = done_pulses;
    clk_bits(32'h8155, 16, rx);
    wait_clk(HALF);
    check("midrst_no_frame_cfg", cfg, mdl_cfg());
    check("midrst_no_frame_cnt", {56'd0, frame_cnt}, 64'd0);
    check("midrst_no_pulse", 64'(done_pulses - pulses0), 64'd0);
    cs_n = 1'b1;
    wait_clk(2*HALF);
    push_frame(); mdl[1] = 8'h55;
    spi_xfer(32'h8155, 16, rx);
    check("post_rst_cfg", cfg, mdl_cfg());
    check("post_rst_frame_cnt", {56'd0, frame_cnt}, 64'd1);

    // 255 more frames bring the total since reset to 256 -> count wraps to 0.
    for (int unsigned i = 0; i < 255; i++) begin
      logic [7:0]  d;
      logic [2:0]  a;
      d = 8'(i * 37 + 1);
      a = 3'(i);
      push_frame(); mdl[a] = d;
      spi_xfer({16'd0, 1'b1, 4'd0, a, d}, 16, rx);
    end
    check("wrap_frame_cnt", {56'd0, frame_cnt}, 64'd0);
    check("wrap_cfg", cfg, mdl_cfg());
    cnt0 = frame_cnt;
    push_frame();
    spi_xfer(32'h0500, 16, rx);
    check("wrap_257_frame_cnt", {56'd0, frame_cnt}, 64'd1);
    check("wrap_257_rd_miso", {48'd0, rx[15:0]}, RB ? {56'd0, mdl[5]} : 64'd0);
    check("wrap_257_step", {56'd0, 8'(frame_cnt - cnt0)}, 64'd1);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/test_cfg_spi_resp.md
TEST_CFG_SPI_RESP -- requirements
Module: test_cfg_spi_resp

Interface
REQ-001 SHALL have parameter RESET_VAL, default 8'h00: value loaded into every configuration register on reset.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: number of synchroniser flops on sclk, cs_n and mosi (legal values 2..3).
REQ-003 SHALL have port clk, input, 1: system clock; all state is updated on the rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port sclk, input, 1: SPI serial clock, mode 0, asynchronous to clk.
REQ-006 SHALL have port cs_n, input, 1: SPI chip select, active-low, asynchronous.
REQ-007 SHALL have port mosi, input, 1: SPI serial data in, sent MSB first.
REQ-008 SHALL have port miso, output, 1: SPI serial data out, sent MSB first.
REQ-009 SHALL have port miso_oe, output, 1: high while the synchronised cs_n is low.
REQ-010 SHALL have port cfg, output, 64: eight 8-bit registers, reg[n] driven on cfg[8n+7:8n].
REQ-011 SHALL have port frame_done, output, 1: one-cycle pulse when a 16-bit frame completes.
REQ-012 SHALL have port frame_cnt, output, 8: count of completed frames, wrapping at 255 to 0.

Function
REQ-013 SHALL pass sclk, cs_n and mosi through SYNC_STAGES flops; edges are detected on the synchronised signals only.
REQ-014 SHALL support an sclk period of at least 8 clk periods; faster sclk is unsupported.
REQ-015 SHALL use the frame format: bit15 = RW (1 = write), bits14:11 reserved and ignored, bits10:8 = address, bits7:0 = data.
REQ-016 SHALL implement the states IDLE, CMD (bits 15..8), DATA (bits 7..0) and DONE.
REQ-017 SHALL move from IDLE to CMD when the synchronised cs_n falls, clearing the 4-bit bit counter and the shift register.
REQ-018 SHALL shift in mosi on each detected sclk rise and increment the bit counter.
REQ-019 SHALL move from CMD to DATA on the 8th rise; on a read, it SHALL load a shadow register from reg[address] in that same cycle.
REQ-020 SHALL drive miso with shadow bit 7 on the next detected sclk fall, then the next lower shadow bit on each following fall.
REQ-021 SHALL hold miso at 0 outside DATA and during write frames.
REQ-022 SHALL, on the 16th rise of a write frame, update reg[address] on the next clk edge; a read frame leaves all registers unchanged.
REQ-023 SHALL, on the 16th rise, pulse frame_done for one cycle, increment frame_cnt, and enter DONE.
REQ-024 SHALL ignore in DONE all sclk edges until cs_n rises; extra bits are discarded.
REQ-025 SHALL, when cs_n rises in any state, go to IDLE in that cycle; a frame aborted before the 16th rise causes no write, no frame_done and no count.
REQ-026 SHALL treat a cs_n rise and a 16th sclk rise detected in the same cycle as a completed frame.

Reset
REQ-027 SHALL, while rst is high, set the state to IDLE, the counter and shadow register to 0, and the synchronisers to idle (sclk 0, cs_n 1, mosi 0).
REQ-028 SHALL drive these values while rst is high: miso 0, miso_oe 0, frame_done 0, frame_cnt 0, every register RESET_VAL.
REQ-029 SHALL, if reset occurs mid-frame, drop that frame, and SHALL NOT start a new frame until cs_n has been seen high and then falls.

Configuration
REQ-030 SHALL use the macro SPI_READBACK_EN: when defined, read frames behave as in REQ-019 and REQ-020.
REQ-031 SHALL, when SPI_READBACK_EN is undefined, omit the shadow register, tie miso and miso_oe to 0, and still count read frames in frame_cnt and frame_done.

Verification
REQ-032 SHALL check: write frame 0x83A5 with RESET_VAL 0 -> cfg[31:24] = 8'hA5, all other bytes 0, one frame_done pulse, frame_cnt = 1.
REQ-033 SHALL check: after REQ-032, read frame 0x0300 -> miso returns 8'hA5 MSB first on DATA bits and cfg is unchanged (with SPI_READBACK_EN).
REQ-034 SHALL check: cs_n raised after 12 bits of write 0x8277 -> cfg[23:16] stays 0, no frame_done pulse, frame_cnt unchanged.
REQ-035 SHALL check: 20 bits clocked with first 16 = 0x8711 -> reg7 = 8'h11, a single frame_done pulse, and trailing bits ignored.
REQ-036 SHALL check: 256 valid frames -> frame_cnt wraps to 0 and the 257th frame gives 1.
REQ-037 SHALL check: rst pulsed after 10 bits of write 0x8155, then cs_n kept low -> reg1 = RESET_VAL and no frame is accepted until cs_n toggles.
